// File: rtl/dadda_mult16_pkg.sv
// Shared constants and the compile-time Dadda schedule for the 16x16 multiplier.
// The functions below are evaluated during elaboration only; they size and wire the tree.
package dadda_pkg;

  localparam int OP_W     = 16;
  localparam int PROD_W   = 32;
  localparam int N_STAGES = 6;
  localparam int N_COLS   = PROD_W;

  localparam int STAGE_TGT [0:N_STAGES-1] = '{13, 9, 6, 4, 3, 2};

  typedef logic [PROD_W-1:0] prod_t;

  localparam int INFO_H    = 0;
  localparam int INFO_FA   = 1;
  localparam int INFO_HA   = 2;
  localparam int INFO_BASE = 3;

  // Returns, for stage s (0 = partial products, N_STAGES = final two rows):
  //   INFO_H    height of column c entering stage s
  //   INFO_FA   full adders placed in column c during stage s
  //   INFO_HA   half adders placed in column c during stage s
  //   INFO_BASE flat bit offset of column c in the stage-s bit vector (c = N_COLS gives total)
  function automatic int tree_info(input int s, input int c, input int kind);
    int h  [N_COLS];
    int hn [N_COLS];
    int fa [N_COLS];
    int ha [N_COLS];
    int cin;
    int tot;
    int r;
    int res;
    int base;
    res = 0;
    for (int k = 0; k < N_COLS; k++) begin
      if (k < OP_W)              h[k] = k + 1;
      else if (k < 2 * OP_W - 1) h[k] = 2 * OP_W - 1 - k;
      else                       h[k] = 0;
    end
    for (int st = 0; st <= N_STAGES; st++) begin
      cin = 0;
      for (int k = 0; k < N_COLS; k++) begin
        fa[k] = 0;
        ha[k] = 0;
        if (st < N_STAGES) begin
          tot = h[k] + cin;
          if (tot > STAGE_TGT[st]) begin
            r     = tot - STAGE_TGT[st];
            fa[k] = r / 2;
            ha[k] = r % 2;
          end
        end
        hn[k] = h[k] - 2 * fa[k] - ha[k] + cin;
        cin   = fa[k] + ha[k];
      end
      if (st == s) begin
        if (kind == INFO_BASE) begin
          base = 0;
          for (int k = 0; k < N_COLS; k++) begin
            if (k < c) base = base + h[k];
          end
          res = base;
        end else if (c < N_COLS) begin
          if (kind == INFO_H)       res = h[c];
          else if (kind == INFO_FA) res = fa[c];
          else                      res = ha[c];
        end
      end
      for (int k = 0; k < N_COLS; k++) h[k] = hn[k];
    end
    return res;
  endfunction

endpackage

// File: rtl/dadda_mult16_fa.sv
// One-bit full adder used for every 3:2 cell of the Dadda tree.
module dadda_fa (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_co
);

  assign o_s  = i_a ^ i_b ^ i_c;
  assign o_co = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);

endmodule

// File: rtl/dadda_mult16.sv
// Unsigned 16x16 -> 32-bit Dadda multiplier with a single output register.
// Each stage is a flat bit vector laid out column by column; offsets come from tree_info().
module dadda_mult16
  import dadda_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              out_valid,
  output logic [PROD_W-1:0] p
);

  localparam int NB_PP  = tree_info(0, N_COLS, INFO_BASE);
  localparam int NB_FIN = tree_info(N_STAGES, N_COLS, INFO_BASE);

  logic [NB_PP-1:0]  w_pp;
  logic [NB_FIN-1:0] w_fin;
  prod_t             w_row0;
  prod_t             w_row1;
  prod_t             w_sum;
  prod_t             r_p;
  logic              r_valid;

  // Partial product a[i]&b[j] lands in column i+j at slot i minus the lowest i in that column.
  for (genvar i = 0; i < OP_W; i++) begin : g_pp_i
    for (genvar j = 0; j < OP_W; j++) begin : g_pp_j
      localparam int COL  = i + j;
      localparam int LO   = (COL >= OP_W) ? COL - (OP_W - 1) : 0;
      localparam int SLOT = tree_info(0, COL, INFO_BASE) + i - LO;
      assign w_pp[SLOT] = a[i] & b[j];
    end
  end

  for (genvar s = 0; s < N_STAGES; s++) begin : g_red
    localparam int NB_IN  = tree_info(s, N_COLS, INFO_BASE);
    localparam int NB_OUT = tree_info(s + 1, N_COLS, INFO_BASE);

    logic [NB_IN-1:0]  w_in;
    logic [NB_OUT-1:0] w_out;

    if (s == 0) begin : g_src_pp
      assign w_in = w_pp;
    end else begin : g_src_prev
      assign w_in = g_red[s-1].w_out;
    end

    for (genvar c = 0; c < N_COLS; c++) begin : g_col
      localparam int H     = tree_info(s, c, INFO_H);
      localparam int NFA   = tree_info(s, c, INFO_FA);
      localparam int NHA   = tree_info(s, c, INFO_HA);
      localparam int NPASS = H - 3 * NFA - 2 * NHA;
      localparam int IB    = tree_info(s, c, INFO_BASE);
      localparam int OB    = tree_info(s + 1, c, INFO_BASE);
      // Output column layout: pass-through bits, FA sums, HA sums, then carries from column c-1.
      localparam int CB    = (c < N_COLS - 1) ?
                             tree_info(s + 1, c + 1, INFO_BASE)
                             + tree_info(s, c + 1, INFO_H)
                             - 2 * tree_info(s, c + 1, INFO_FA)
                             - tree_info(s, c + 1, INFO_HA) : 0;

      for (genvar k = 0; k < NPASS; k++) begin : g_pass
        assign w_out[OB+k] = w_in[IB+3*NFA+2*NHA+k];
      end

      for (genvar f = 0; f < NFA; f++) begin : g_fa
        dadda_fa u_fa (
          .i_a  (w_in[IB+3*f]),
          .i_b  (w_in[IB+3*f+1]),
          .i_c  (w_in[IB+3*f+2]),
          .o_s  (w_out[OB+NPASS+f]),
          .o_co (w_out[CB+f])
        );
      end

      for (genvar g = 0; g < NHA; g++) begin : g_ha
        assign w_out[OB+NPASS+NFA+g] = w_in[IB+3*NFA+2*g] ^ w_in[IB+3*NFA+2*g+1];
        assign w_out[CB+NFA+g]       = w_in[IB+3*NFA+2*g] & w_in[IB+3*NFA+2*g+1];
      end
    end
  end

  assign w_fin = g_red[N_STAGES-1].w_out;

  // After the last stage every column holds at most two bits; split them into two rows.
  for (genvar c = 0; c < N_COLS; c++) begin : g_rows
    localparam int HF = tree_info(N_STAGES, c, INFO_H);
    localparam int FB = tree_info(N_STAGES, c, INFO_BASE);
    if (HF > 0) begin : g_r0
      assign w_row0[c] = w_fin[FB];
    end else begin : g_r0_zero
      assign w_row0[c] = 1'b0;
    end
    if (HF > 1) begin : g_r1
      assign w_row1[c] = w_fin[FB+1];
    end else begin : g_r1_zero
      assign w_row1[c] = 1'b0;
    end
  end

  // The true product fits in 32 bits, so the dropped carry out of bit 31 is always zero.
  assign w_sum = w_row0 + w_row1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_p     <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) r_p <= w_sum;
    end
  end

  assign p         = r_p;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_dadda_mult16.sv
// Scoreboarded bench for dadda_mult16: the driver predicts {out_valid, p} per cycle,
// the monitor pops one prediction after every rising edge and compares.
module tb_dadda_mult16;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic [31:0] p;

  logic [32:0] exp_q[$];
  logic        m_v;
  logic [31:0] m_p;
  int          n_checks;
  int          n_fail;

  dadda_mult16 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .p         (p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one cycle of inputs at the falling edge and predicts the state after the next rising edge.
  task automatic drive(input logic r, input logic v, input logic [15:0] aa, input logic [15:0] bb);
    logic [31:0] wa;
    logic [31:0] wb;
    @(negedge clk);
    rst      = r;
    in_valid = v;
    a        = aa;
    b        = bb;
    wa = {16'd0, aa};
    wb = {16'd0, bb};
    if (r) begin
      m_v = 1'b0;
      m_p = 32'd0;
    end else begin
      m_v = v;
      if (v) m_p = wa * wb;
    end
    exp_q.push_back({m_v, m_p});
  endtask

  // Monitor: one prediction per rising edge once the driver has started.
  initial begin : monitor
    logic [32:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({out_valid, p} !== e) begin
          n_fail++;
          $display("FAIL out_check #%0d: got out_valid=%0b p=%0d (0x%08h), expected out_valid=%0b p=%0d (0x%08h)",
                   n_checks, out_valid, p, p, e[32], e[31:0], e[31:0]);
        end
      end
    end
  end

  initial begin : stimulus
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rv;
    n_checks = 0;
    n_fail   = 0;
    m_v      = 1'b0;
    m_p      = 32'd0;
    rst      = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;

    // Reset with random operands, then release idle.
    repeat (2) drive(1'b1, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
    drive(1'b0, 1'b0, 16'($urandom), 16'($urandom));
    drive(1'b0, 1'b0, 16'($urandom), 16'($urandom));

    // Directed pairs, back to back.
    drive(1'b0, 1'b1, 16'd7239,  16'd49998);
    drive(1'b0, 1'b1, 16'd23230, 16'd44371);
    drive(1'b0, 1'b1, 16'd65535, 16'd65534);
    drive(1'b0, 1'b1, 16'd65535, 16'd65535);
    drive(1'b0, 1'b0, 16'd1234,  16'd5678);

    // Corners.
    drive(1'b0, 1'b1, 16'd0,     16'd65535);
    drive(1'b0, 1'b1, 16'd1,     16'd40000);
    drive(1'b0, 1'b1, 16'd32768, 16'd2);
    drive(1'b0, 1'b1, 16'd65535, 16'd0);
    drive(1'b0, 1'b0, 16'd0,     16'd0);

    // One-hot sweep.
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        drive(1'b0, 1'b1, 16'(1 << i), 16'(1 << j));
      end
    end

    // Reset the cycle after a valid pair, then reset concurrent with a valid pair.
    drive(1'b0, 1'b1, 16'd50000, 16'd60000);
    drive(1'b1, 1'b1, 16'd333,   16'd444);
    drive(1'b0, 1'b0, 16'd777,   16'd888);
    drive(1'b0, 1'b1, 16'd4321,  16'd8765);
    drive(1'b1, 1'b1, 16'd65535, 16'd65535);
    drive(1'b0, 1'b0, 16'd1,     16'd1);
    drive(1'b0, 1'b1, 16'd12345, 16'd54321);

    // Random traffic with idle gaps.
    for (int n = 0; n < 10000; n++) begin
      rv = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 9))
        0:       ra = 16'hFFFF;
        1:       ra = 16'h0000;
        default: ra = 16'($urandom);
      endcase
      case ($urandom_range(0, 9))
        0:       rb = 16'hFFFF;
        1:       rb = 16'h0001;
        default: rb = 16'($urandom);
      endcase
      drive(1'b0, rv, ra, rb);
    end
    drive(1'b0, 1'b0, 16'd0, 16'd0);

    // Drain with a bounded wait.
    for (int w = 0; w < 20 && exp_q.size() != 0; w++) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d predictions still pending, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
